// File: rtl/data_mem_ctrl.sv
// Data-memory controller for the load/store path: valid/ready request and
// response handshakes, B/H/W/D accesses, byte-enable stores, extended loads.
//
// Ports:
//   clk, rst (sync, active-low)
//   req_valid/req_ready/req_write/req_size/req_unsigned/req_addr/req_wdata
//   resp_valid/resp_ready/resp_rdata/resp_err
module data_mem_ctrl #(
    parameter int XLEN      = 64,
    parameter int DEPTH     = 256,
    parameter int ADDR_W    = 64,
    parameter int LATENCY   = 1,
    parameter     INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic              resp_err
);

    localparam int NB       = XLEN / 8;
    localparam int OFF_W    = $clog2(NB);
    localparam int IDX_W    = $clog2(DEPTH);
    localparam int CNT_INIT = (LATENCY > 1) ? LATENCY - 2 : 0;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t state, state_n;
    logic [2:0] cnt, cnt_n;
    logic accept;

    logic [XLEN-1:0] mem [DEPTH];

    // Request decode, valid only in the accept cycle
    logic [OFF_W-1:0]  off;
    logic [ADDR_W-1:0] word_full;
    logic [IDX_W-1:0]  idx;
    logic [NB-1:0]     be_base, be;
    logic [OFF_W-1:0]  amask;
    logic              err;
    logic [XLEN-1:0]   wsh;
    logic [XLEN-1:0]   rd_word, field, ext;

    assign off       = req_addr[OFF_W-1:0];
    assign word_full = req_addr >> OFF_W;
    assign idx       = word_full[IDX_W-1:0];

    always_comb begin
        be_base = '0;
        amask   = '0;
        unique case (req_size)
            2'd0: begin be_base = NB'(1);   amask = OFF_W'(0); end
            2'd1: begin be_base = NB'(3);   amask = OFF_W'(1); end
            2'd2: begin be_base = NB'(15);  amask = OFF_W'(3); end
            2'd3: begin be_base = NB'(255); amask = OFF_W'(7); end
        endcase
    end

    // Word index checked at full address width: no wrap-around
    assign err = (|(off & amask))
               || (word_full >= ADDR_W'(DEPTH))
               || (XLEN == 32 && req_size == 2'd3);

    assign be  = be_base << off;
    assign wsh = req_wdata << {off, 3'b000};

    assign rd_word = mem[idx];
    assign field   = rd_word >> {off, 3'b000};

    always_comb begin
        ext = field;
        unique case (req_size)
            2'd0: ext = req_unsigned ? XLEN'(field[7:0])
                                     : XLEN'($signed(field[7:0]));
            2'd1: ext = req_unsigned ? XLEN'(field[15:0])
                                     : XLEN'($signed(field[15:0]));
            2'd2: ext = req_unsigned ? XLEN'(field[31:0])
                                     : XLEN'($signed(field[31:0]));
            2'd3: ext = field;
        endcase
    end

    // FSM
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        accept     = 1'b0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    accept  = 1'b1;
                    cnt_n   = 3'(CNT_INIT);
                    state_n = (LATENCY > 1) ? WAIT : RESP;
                end
            end
            WAIT: begin
                if (cnt == '0) state_n = RESP;
                else           cnt_n   = cnt - 3'd1;
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Response registers, loaded at accept and held until the next accept
    always_ff @(posedge clk) begin
        if (!rst) begin
            resp_rdata <= '0;
            resp_err   <= 1'b0;
        end else if (accept) begin
            resp_err   <= err;
            resp_rdata <= (err || req_write) ? '0 : ext;
        end
    end

    // RAM write port; gated by rst so a store at a reset edge is dropped
    always_ff @(posedge clk) begin
        if (rst && accept && req_write && !err) begin
            for (int i = 0; i < NB; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wsh[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (XLEN 64, DEPTH 16, LATENCY 3).
// Immediate assertions at each comparison point.
module tb_data_mem_ctrl;

    localparam int XLEN = 64;
    localparam int DEPTH = 16;
    localparam int LAT = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [63:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .XLEN(XLEN), .DEPTH(DEPTH), .ADDR_W(64), .LATENCY(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input bit wr, input logic [1:0] sz, input bit uns,
                         input logic [63:0] a, input logic [63:0] wd);
        req_valid    = 1'b1;
        req_write    = wr;
        req_size     = sz;
        req_unsigned = uns;
        req_addr     = a;
        req_wdata    = wd;
    endtask

    task automatic wait_resp(output int lat);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!resp_valid && lat < 20);
    endtask

    task automatic xact(input string tag, input bit wr, input logic [1:0] sz,
                        input bit uns, input logic [63:0] a,
                        input logic [63:0] wd,
                        output logic [63:0] rd, output logic er,
                        output int lat);
        int n;
        @(negedge clk);
        drive(wr, sz, uns, a, wd);
        n = 0;
        while (!req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        chk({tag, "_valid"}, 64'(resp_valid), 64'd1);
        rd = resp_rdata;
        er = resp_err;
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
    endtask

    logic [63:0] rd, r0;
    logic        er;
    int          lat;
    int          seen;

    initial begin
        // Reset
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 64'(resp_valid), 64'd0);
        chk("rst_rdata", resp_rdata, 64'd0);
        chk("rst_err", 64'(resp_err), 64'd0);
        rst = 1'b1;

        // 1: D store / D load, latency
        xact("t1_st", 1, 2'd3, 0, 64'h10, 64'h1122334455667788, rd, er, lat);
        chk("t1_st_rdata", rd, 64'd0);
        chk("t1_st_err", 64'(er), 64'd0);
        xact("t1_ld", 0, 2'd3, 0, 64'h10, 64'h0, rd, er, lat);
        chk("t1_ld_rdata", rd, 64'h1122334455667788);
        chk("t1_ld_err", 64'(er), 64'd0);
        chk("t1_latency", 64'(lat), 64'd3);

        // 2: byte store merge, extended loads
        xact("t2_st", 1, 2'd0, 0, 64'h13, 64'hFFFF_FFAB, rd, er, lat);
        xact("t2_ld", 0, 2'd3, 0, 64'h10, 64'h0, rd, er, lat);
        chk("t2_merge", rd, 64'h11223344AB667788);
        xact("t2_lbs", 0, 2'd0, 0, 64'h13, 64'h0, rd, er, lat);
        chk("t2_lb_signed", rd, 64'hFFFFFFFFFFFFFFAB);
        xact("t2_lbu", 0, 2'd0, 1, 64'h13, 64'h0, rd, er, lat);
        chk("t2_lb_unsigned", rd, 64'h00000000000000AB);
        xact("t2_lws", 0, 2'd2, 0, 64'h10, 64'h0, rd, er, lat);
        chk("t2_lw_signed", rd, 64'hFFFFFFFFAB667788);
        xact("t2_lhu", 0, 2'd1, 1, 64'h12, 64'h0, rd, er, lat);
        chk("t2_lh_unsigned", rd, 64'h000000000000AB66);

        // 3: misaligned accesses
        xact("t3_lh", 0, 2'd1, 0, 64'h11, 64'h0, rd, er, lat);
        chk("t3_lh_err", 64'(er), 64'd1);
        chk("t3_lh_rdata", rd, 64'd0);
        xact("t3_pre", 1, 2'd3, 0, 64'h08, 64'hCAFEBABE01234567, rd, er, lat);
        xact("t3_sw", 1, 2'd2, 0, 64'h0E, 64'h99999999, rd, er, lat);
        chk("t3_sw_err", 64'(er), 64'd1);
        xact("t3_ld", 0, 2'd3, 0, 64'h08, 64'h0, rd, er, lat);
        chk("t3_unchanged", rd, 64'hCAFEBABE01234567);

        // 4: range boundary
        xact("t4_w0", 1, 2'd3, 0, 64'h00, 64'h0F0F0F0F0F0F0F0F, rd, er, lat);
        xact("t4_last", 1, 2'd3, 0, 64'(8*(DEPTH-1)), 64'h7777666655554444,
             rd, er, lat);
        chk("t4_last_err", 64'(er), 64'd0);
        xact("t4_last_rd", 0, 2'd3, 0, 64'(8*(DEPTH-1)), 64'h0, rd, er, lat);
        chk("t4_last_data", rd, 64'h7777666655554444);
        xact("t4_oor", 1, 2'd3, 0, 64'(8*DEPTH), 64'hDEADDEADDEADDEAD,
             rd, er, lat);
        chk("t4_oor_err", 64'(er), 64'd1);
        xact("t4_oor_ld", 0, 2'd3, 0, 64'(8*DEPTH), 64'h0, rd, er, lat);
        chk("t4_oor_ld_err", 64'(er), 64'd1);
        chk("t4_oor_ld_rdata", rd, 64'd0);
        xact("t4_hi", 0, 2'd3, 0, 64'h1000_0000_0000_0000, 64'h0, rd, er, lat);
        chk("t4_hi_err", 64'(er), 64'd1);
        xact("t4_w0_rd", 0, 2'd3, 0, 64'h00, 64'h0, rd, er, lat);
        chk("t4_w0_kept", rd, 64'h0F0F0F0F0F0F0F0F);
        xact("t4_last_rd2", 0, 2'd3, 0, 64'(8*(DEPTH-1)), 64'h0, rd, er, lat);
        chk("t4_last_kept", rd, 64'h7777666655554444);

        // 5: response stall
        xact("t5_pre", 1, 2'd3, 0, 64'h30, 64'h0101, rd, er, lat);
        @(negedge clk);
        drive(0, 2'd3, 0, 64'h10, 64'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        r0 = resp_rdata;
        chk("t5_rdata", r0, 64'h11223344AB667788);
        drive(1, 2'd3, 0, 64'h30, 64'h5555);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_stall_valid", 64'(resp_valid), 64'd1);
            chk("t5_stall_rdata", resp_rdata, r0);
            chk("t5_stall_err", 64'(resp_err), 64'd0);
            chk("t5_stall_ready", 64'(req_ready), 64'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        @(negedge clk);
        chk("t5_post_ready", 64'(req_ready), 64'd1);
        chk("t5_post_valid", 64'(resp_valid), 64'd0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        wait_resp(lat);
        chk("t5_st_valid", 64'(resp_valid), 64'd1);
        chk("t5_st_lat", 64'(lat), 64'd3);
        resp_ready = 1'b1;
        @(posedge clk);
        #1 resp_ready = 1'b0;
        xact("t5_ld", 0, 2'd3, 0, 64'h30, 64'h0, rd, er, lat);
        chk("t5_ld_data", rd, 64'h5555);

        // 6: reset at a store accept edge, reset during WAIT
        xact("t6_pre", 1, 2'd3, 0, 64'h20, 64'h0BAD0BAD, rd, er, lat);
        @(negedge clk);
        drive(1, 2'd3, 0, 64'h20, 64'hDEAD);
        rst = 1'b0;
        @(negedge clk);
        chk("t6_rst_valid", 64'(resp_valid), 64'd0);
        chk("t6_rst_rdata", resp_rdata, 64'd0);
        req_valid = 1'b0;
        rst = 1'b1;
        xact("t6_ld", 0, 2'd3, 0, 64'h20, 64'h0, rd, er, lat);
        chk("t6_old_value", rd, 64'h0BAD0BAD);

        @(negedge clk);
        drive(0, 2'd3, 0, 64'h20, 64'h0);
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        chk("t6_wait_dropped", 64'(seen), 64'd0);
        chk("t6_wait_ready", 64'(req_ready), 64'd1);
        xact("t6_after", 0, 2'd3, 0, 64'h08, 64'h0, rd, er, lat);
        chk("t6_after_data", rd, 64'hCAFEBABE01234567);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
